// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Holds the FSM state enum and the default operand width.
package div_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
// Ports: rem_in/quo_in current partial state, B divisor; rem_out/quo_out next state.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    // Shifted remainder needs WIDTH+1 bits: rem < B, so 2*rem+1 may
    // exceed WIDTH bits when B is close to the top of the range.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, B};
        ge      = shifted >= {1'b0, B};
        rem_out = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div8_seq.sv
// Sequential unsigned restoring divider with valid/ready handshakes.
// Ports: in_valid/in_ready + A,B operands; out_valid/out_ready + Q,R,div0 result.
module div8_seq
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div0
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_t       state;
    div_state_t       state_nx;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             div0_q;
    logic [CW-1:0]    cnt_q;
    logic             accept;
    logic             last_step;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .B       (b_q),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Handshake outputs depend on state only, never on in_valid/out_ready.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = (B == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Result registers are separate from the working registers so
    // Q/R keep their last values while a new division is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            b_q    <= '0;
            q_q    <= '0;
            r_q    <= '0;
            div0_q <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            b_q   <= B;
            cnt_q <= '0;
            if (B == '0) begin
                q_q    <= '1;
                r_q    <= A;
                div0_q <= 1'b1;
            end else begin
                rem_q <= '0;
                quo_q <= A;
            end
        end else if (state == BUSY) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + CW'(1);
            if (last_step) begin
                q_q    <= quo_nx;
                r_q    <= rem_nx;
                div0_q <= 1'b0;
            end
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign div0 = div0_q;

endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: directed table, reset abort, random ops.
// Expected results come from plain integer division in the bench.
module tb_div8_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Q;
    logic [7:0] R;
    logic       div0;

    int n_chk;
    int n_fail;

    div8_seq #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .div0      (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       d;
        int         lat;
        int         stall;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_op(
        input logic [7:0] a,
        input logic [7:0] b,
        input int         stall,
        input logic [7:0] eq,
        input logic [7:0] er,
        input logic       ed,
        input int         elat,
        input string      tag
    );
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk({tag, "_in_ready_timeout"}, 0, 1);
            return;
        end
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(negedge clk);
        lat = 1;
        while (1) begin
            in_valid = 1'($urandom);
            A        = 8'($urandom);
            B        = 8'($urandom);
            if (out_valid || lat >= 40) break;
            out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            in_valid  = 1'b0;
            out_ready = 1'b0;
            chk({tag, "_out_valid_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_Q"}, int'(Q), int'(eq));
        chk({tag, "_R"}, int'(R), int'(er));
        chk({tag, "_div0"}, int'(div0), int'(ed));
        chk({tag, "_in_ready_busy"}, int'(in_ready), 0);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            @(negedge clk);
            in_valid = 1'($urandom);
            chk({tag, "_hold_valid"}, int'(out_valid), 1);
            chk({tag, "_hold_Q"}, int'(Q), int'(eq));
            chk({tag, "_hold_R"}, int'(R), int'(er));
            chk({tag, "_hold_in_ready"}, int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, int'(out_valid), 0);
        chk({tag, "_post_in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rq;
        logic [7:0] rr;
        logic       rd;
        int         seen;

        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;

        tv[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 9, 0};
        tv[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9, 1};
        tv[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9, 0};
        tv[3] = '{8'd13,  8'd0,   8'd255, 8'd13,  1'b1, 1, 2};
        tv[4] = '{8'd100, 8'd10,  8'd10,  8'd0,   1'b0, 9, 5};
        tv[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9, 0};
        tv[6] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9, 1};
        tv[7] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 9, 0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_Q", int'(Q), 0);
        chk("rst_R", int'(R), 0);
        chk("rst_div0", int'(div0), 0);

        for (int i = 0; i < 8; i++) begin
            run_op(tv[i].a, tv[i].b, tv[i].stall, tv[i].q,
                   tv[i].r, tv[i].d, tv[i].lat, $sformatf("vec%0d", i));
        end

        // Abort 200/7 part way through, then check recovery.
        A        = 8'd200;
        B        = 8'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_Q", int'(Q), 0);
        chk("abort_R", int'(R), 0);
        chk("abort_div0", int'(div0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", int'(in_ready), 1);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 0);
        run_op(8'd17, 8'd3, 1, 8'd5, 8'd2, 1'b0, 9, "after_abort");

        for (int k = 0; k < 3000; k++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 8'd0;
                1:       rb = 8'($urandom_range(1, 15));
                default: rb = 8'($urandom);
            endcase
            if (rb == 8'd0) begin
                rq = 8'hFF;
                rr = ra;
                rd = 1'b1;
            end else begin
                rq = ra / rb;
                rr = ra % rb;
                rd = 1'b0;
            end
            run_op(ra, rb, $urandom_range(0, 2), rq, rr, rd,
                   (rb == 8'd0) ? 1 : 9, $sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
